input_holder: RTL and testbench

- Host-side ingress buffer for the stream cipher; the mirror of the output holder.
- Samples the user's byte pins on each rising edge of an asynchronous load strobe.
- Queues captured bytes in a small FIFO and issues each one to the encryption block as a single-cycle pulse when the cipher is ready.
- Reports fill state to the interface FSM and flags dropped bytes.

---
 rtl/input_holder.sv | 158 +++++++++++++++
 tb/tb_input_holder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/input_holder.sv
// Host-side ingress buffer: synchronizes the user's byte pins and load strobe,
// queues captured bytes, and issues them to the cipher as single-cycle pulses.

package types_pkg;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_LOAD = 2'd1,
    I_RUN  = 2'd2,
    I_DONE = 2'd3
  } interface_state_t;

  typedef enum logic [1:0] {
    IN_EMPTY   = 2'd0,
    IN_PARTIAL = 2'd1,
    IN_FULL    = 2'd2
  } input_holder_state_t;

endpackage

module input_holder
  import types_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          pin_data,
  input  logic                pin_load,
  input  interface_state_t    interface_state,
  input  logic                cipher_ready,
  output logic [7:0]          data_out,
  output logic                data_out_pulse,
  output input_holder_state_t input_holder_state_out,
  output logic                overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // Synchronizer chains; data travels alongside its strobe so they stay aligned.
  logic [SYNC_STAGES-1:0] load_sync_q;
  logic [7:0]             data_sync_q [SYNC_STAGES];
  logic                   load_prev_q;

  logic                   push;
  logic [7:0]             push_data;

  // FIFO state
  logic [7:0]             mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  // Output registers
  logic [7:0]             data_out_q, data_out_d;
  logic                   pulse_q, pulse_d;
  input_holder_state_t    state_q, state_d;
  logic                   overflow_q, overflow_d;

  logic                   pop;
  logic                   full;
  logic                   push_ok;
  logic                   drop;

  // Shift pin_load and pin_data through matching synchronizer stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_sync_q <= '0;
      load_prev_q <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= '0;
      end
    end else begin
      load_sync_q    <= {load_sync_q[SYNC_STAGES-2:0], pin_load};
      load_prev_q    <= load_sync_q[SYNC_STAGES-1];
      data_sync_q[0] <= pin_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  assign push      = load_sync_q[SYNC_STAGES-1] & ~load_prev_q;
  assign push_data = data_sync_q[SYNC_STAGES-1];

  // Next-state: issue, FIFO bookkeeping, fill state and sticky overflow.
  always_comb begin
    pop        = 1'b0;
    full       = 1'b0;
    push_ok    = 1'b0;
    drop       = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    pulse_d    = 1'b0;
    state_d    = state_q;
    overflow_d = overflow_q;

    // A pulse in flight blocks the next issue, so pulses are at least 2 apart.
    pop     = (count_q != '0) & cipher_ready & ~pulse_q;
    full    = (count_q == DepthCnt);
    // A pop on the same edge frees the slot even when full.
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;

    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      data_out_d = mem_q[rd_ptr_q];
      pulse_d    = 1'b1;
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop);

    if (count_d == '0)           state_d = IN_EMPTY;
    else if (count_d == DepthCnt) state_d = IN_FULL;
    else                          state_d = IN_PARTIAL;

    // Set beats clear when a drop coincides with I_IDLE.
    if (drop)                          overflow_d = 1'b1;
    else if (interface_state == I_IDLE) overflow_d = 1'b0;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      pulse_q    <= 1'b0;
      state_q    <= IN_EMPTY;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      pulse_q    <= pulse_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; unreset because pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign data_out               = data_out_q;
  assign data_out_pulse         = pulse_q;
  assign input_holder_state_out = state_q;
  assign overflow               = overflow_q;

endmodule

// File: tb/tb_input_holder.sv
// Self-checking bench for input_holder: scoreboard of expected issued bytes
// plus directed timing and flag checks.

module tb_input_holder;
  import types_pkg::*;

  logic                clk;
  logic                rst;
  logic [7:0]          pin_data;
  logic                pin_load;
  interface_state_t    interface_state;
  logic                cipher_ready;
  logic [7:0]          data_out;
  logic                data_out_pulse;
  input_holder_state_t input_holder_state_out;
  logic                overflow;

  int n_checks = 0;
  int n_fails  = 0;
  int n_pulses = 0;
  int base;
  logic       prev_pulse = 1'b0;
  logic [7:0] sb [$];

  input_holder #(
    .DEPTH       (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .pin_data               (pin_data),
    .pin_load               (pin_load),
    .interface_state        (interface_state),
    .cipher_ready           (cipher_ready),
    .data_out               (data_out),
    .data_out_pulse         (data_out_pulse),
    .input_holder_state_out (input_holder_state_out),
    .overflow               (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising edge, held long enough to cross the synchronizer, then released.
  task automatic load_byte(input logic [7:0] b);
    pin_data = b;
    pin_load = 1'b1;
    repeat (4) tick();
    pin_load = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    check("drain", 32'(sb.size()), 0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (data_out_pulse) begin
      n_pulses++;
      check("back_to_back", 32'(prev_pulse), 0);
      if (sb.size() == 0) check("unexpected_pulse", 32'(sb.size()), 1);
      else check("data_out", 32'(data_out), 32'(sb.pop_front()));
    end
    prev_pulse = data_out_pulse;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pin_load = 1'b0; pin_data = '0;
    cipher_ready = 1'b0; interface_state = I_RUN;
    repeat (3) tick();
    check("rst_pulse", 32'(data_out_pulse), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_state", 32'(input_holder_state_out), IN_EMPTY);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    tick();

    // Basic latency: sampled at edge k, push at k+2, pulse after k+3.
    cipher_ready = 1'b1;
    pin_data = 8'hA5; pin_load = 1'b1; sb.push_back(8'hA5);
    tick(); tick();
    check("lat_early", 32'(data_out_pulse), 0);
    tick();
    check("push_state", 32'(input_holder_state_out), IN_PARTIAL);
    check("push_nopulse", 32'(data_out_pulse), 0);
    tick();
    check("issue_pulse", 32'(data_out_pulse), 1);
    check("issue_data", 32'(data_out), 8'hA5);
    check("issue_state", 32'(input_holder_state_out), IN_EMPTY);
    tick();
    check("one_cycle", 32'(data_out_pulse), 0);
    check("hold_data", 32'(data_out), 8'hA5);
    pin_load = 1'b0;
    repeat (3) tick();

    // Backpressure and overflow drop.
    cipher_ready = 1'b0;
    sb.push_back(8'h11); sb.push_back(8'h22);
    load_byte(8'h11);
    check("bp_partial", 32'(input_holder_state_out), IN_PARTIAL);
    load_byte(8'h22);
    check("bp_full", 32'(input_holder_state_out), IN_FULL);
    check("bp_no_ovf", 32'(overflow), 0);
    load_byte(8'h33);
    check("bp_ovf", 32'(overflow), 1);
    check("bp_still_full", 32'(input_holder_state_out), IN_FULL);
    cipher_ready = 1'b1;
    drain(10);
    check("bp_empty", 32'(input_holder_state_out), IN_EMPTY);
    check("ovf_sticky", 32'(overflow), 1);

    // I_IDLE clears overflow.
    interface_state = I_IDLE; tick(); interface_state = I_RUN;
    check("ovf_clear", 32'(overflow), 0);

    // Drop coinciding with I_IDLE: set wins.
    cipher_ready = 1'b0;
    sb.push_back(8'h44); sb.push_back(8'h55);
    load_byte(8'h44);
    load_byte(8'h55);
    pin_data = 8'h66; pin_load = 1'b1;
    tick(); tick();
    interface_state = I_IDLE;
    tick();
    interface_state = I_RUN;
    check("ovf_set_wins", 32'(overflow), 1);
    pin_load = 1'b0;
    repeat (3) tick();
    interface_state = I_IDLE; tick(); interface_state = I_RUN;
    check("ovf_clear2", 32'(overflow), 0);
    cipher_ready = 1'b1;
    drain(10);

    // Push landing on the pop edge while full.
    cipher_ready = 1'b0;
    sb.push_back(8'h71); sb.push_back(8'h72); sb.push_back(8'h73);
    load_byte(8'h71);
    load_byte(8'h72);
    pin_data = 8'h73; pin_load = 1'b1;
    tick(); tick();
    cipher_ready = 1'b1;
    tick();
    check("pp_full", 32'(input_holder_state_out), IN_FULL);
    check("pp_no_ovf", 32'(overflow), 0);
    check("pp_pulse", 32'(data_out_pulse), 1);
    pin_load = 1'b0;
    drain(12);
    check("pp_no_ovf_end", 32'(overflow), 0);

    // Held level gives one push; three toggles give three.
    base = n_pulses;
    pin_data = 8'h5A; pin_load = 1'b1; sb.push_back(8'h5A);
    repeat (20) tick();
    pin_load = 1'b0;
    repeat (4) tick();
    check("level_one_push", 32'(n_pulses - base), 1);
    base = n_pulses;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'(8'h01 + i));
      load_byte(8'(8'h01 + i));
    end
    repeat (4) tick();
    check("toggle_three", 32'(n_pulses - base), 3);
    check("toggle_sb_empty", 32'(sb.size()), 0);

    // Reset with two bytes queued and a pulse high.
    cipher_ready = 1'b0;
    base = n_pulses;
    sb.push_back(8'hD1);
    load_byte(8'hD1);
    load_byte(8'hD2);
    pin_data = 8'hD3; pin_load = 1'b1;
    tick(); tick();
    cipher_ready = 1'b1;
    tick();
    check("pre_rst_pulse", 32'(data_out_pulse), 1);
    check("pre_rst_data", 32'(data_out), 8'hD1);
    check("pre_rst_full", 32'(input_holder_state_out), IN_FULL);
    rst = 1'b1; pin_load = 1'b0;
    tick();
    check("mid_rst_pulse", 32'(data_out_pulse), 0);
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_state", 32'(input_holder_state_out), IN_EMPTY);
    check("mid_rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    repeat (12) tick();
    check("post_rst_state", 32'(input_holder_state_out), IN_EMPTY);
    check("post_rst_no_stale", 32'(n_pulses - base), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
